proc_control: RTL

Control unit of the multicycle processor. Sequences the datapath (register file R0–R7, A register, ALU, G register, IR and the shared bus) through the time steps of each instruction. Steps are tracked by a 3-bit step counter. The block accepts a `run` start pulse, then drives the one-hot register enables, the bus-source selects and the ALU operation, and raises `done` on the last step.

---
 rtl/proc_pkg.sv | 55 +++++
 rtl/upcount.sv | 21 ++
 rtl/proc_control.sv | 101 ++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor control path:
// opcodes, ALU function codes, time steps and IR field positions.
package proc_pkg;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3
    } step_e;

    localparam int IR_OP_MSB = 8;
    localparam int IR_OP_LSB = 6;
    localparam int IR_RX_MSB = 5;
    localparam int IR_RX_LSB = 3;
    localparam int IR_RY_MSB = 2;
    localparam int IR_RY_LSB = 0;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/upcount.sv
// 3-bit step counter: synchronous clear, otherwise increments every cycle.
module upcount (
    input  logic       clk,
    input  logic       clr,
    output logic [2:0] q
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = clr ? 3'd0 : count_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign q = count_q;

endmodule

// File: rtl/proc_control.sv
// Control unit of the multicycle processor: decodes the current step and IR
// into register enables, bus-source selects and the ALU function.
module proc_control
    import proc_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       run,
    input  logic [8:0] ir,
    output logic       ir_in,
    output logic [7:0] r_in,
    output logic [7:0] r_out,
    output logic       din_out,
    output logic       g_out,
    output logic       a_in,
    output logic       g_in,
    output logic [1:0] alu_op,
    output logic       done,
    output logic [2:0] step
);

    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_hot;
    logic [7:0] ry_hot;
    logic [2:0] step_cnt;
    logic       step_clr;

    assign op     = ir[IR_OP_MSB:IR_OP_LSB];
    assign rx     = ir[IR_RX_MSB:IR_RX_LSB];
    assign ry     = ir[IR_RY_MSB:IR_RY_LSB];
    assign rx_hot = onehot8(rx);
    assign ry_hot = onehot8(ry);

    // Counter returns to T0 after the last step, and idles in T0 until run.
    assign step_clr = clear | done | ((step_cnt == T0) & ~run);

    upcount u_step (
        .clk (clk),
        .clr (step_clr),
        .q   (step_cnt)
    );

    assign step = clear ? 3'd0 : step_cnt;

    // Out-of-range steps and non-ALU opcodes past T1 decode as done so the
    // counter always recovers to T0.
    always_comb begin
        ir_in   = 1'b0;
        r_in    = 8'h00;
        r_out   = 8'h00;
        din_out = 1'b0;
        g_out   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = ALU_ADD;
        done    = 1'b0;
        if (!clear) begin
            case (step_cnt)
                T0: begin
                    ir_in = run;
                end
                T1: begin
                    done = 1'b1;
                    if (op == OP_MV) begin
                        r_out = ry_hot;
                        r_in  = rx_hot;
                    end else if (op == OP_MVI) begin
                        din_out = 1'b1;
                        r_in    = rx_hot;
                    end else if (is_alu_op(op)) begin
                        r_out = rx_hot;
                        a_in  = 1'b1;
                        done  = 1'b0;
                    end
                end
                T2: begin
                    if (is_alu_op(op)) begin
                        r_out  = ry_hot;
                        g_in   = 1'b1;
                        alu_op = alu_code(op);
                    end else begin
                        done = 1'b1;
                    end
                end
                T3: begin
                    done = 1'b1;
                    if (is_alu_op(op)) begin
                        g_out = 1'b1;
                        r_in  = rx_hot;
                    end
                end
                default: begin
                    done = 1'b1;
                end
            endcase
        end
    end

endmodule
